// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for counter_load_arbiter: FSM state encoding, owner
// index width and the one-hot to index helper.
package counter_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam int OWNER_W = 3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    RUN  = ST_RUN
  } state_t;

  // One-hot (up to 8 requesters) to binary index; zero input maps to 0.
  function automatic logic [OWNER_W-1:0] onehot_to_idx(input logic [7:0] oh);
    logic [OWNER_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | OWNER_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/counter_load_arbiter_if.sv
// Requester / counter-side bundle of counter_load_arbiter.
// Optional macro WATCHDOG_EN adds the err output.
//
// Handshake: a requester holds req[i] high until it sees its one-cycle
// gnt[i] pulse; done (or err) pulses once when that requester's run ends.
// load/data_out form a single-cycle command to the counter, and count_in
// is sampled every cycle while a run is active.
interface counter_load_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);
  import counter_ctrl_pkg::*;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  load;
  logic [WIDTH-1:0]      data_out;
  logic [WIDTH-1:0]      count_in;
  logic                  busy;
  logic [OWNER_W-1:0]    owner;
  logic                  done;
  logic [1:0]            dbg_state;
`ifdef WATCHDOG_EN
  logic                  err;
`endif

`ifdef WATCHDOG_EN
  modport master (
    input  req, req_data, count_in,
    output gnt, load, data_out, busy, owner, done, dbg_state, err
  );
  modport slave (
    output req, req_data, count_in,
    input  gnt, load, data_out, busy, owner, done, dbg_state, err
  );
`else
  modport master (
    input  req, req_data, count_in,
    output gnt, load, data_out, busy, owner, done, dbg_state
  );
  modport slave (
    output req, req_data, count_in,
    input  gnt, load, data_out, busy, owner, done, dbg_state
  );
`endif

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: combinational search upward from (last grantee + 1),
// plus the register holding the last grantee.
module rr_arbiter
  import counter_ctrl_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic               upd,
  input  logic [OWNER_W-1:0] upd_idx,
  output logic [NREQ-1:0]    gnt,
  output logic               any
);

  logic [OWNER_W-1:0] last_q;
  int                 pick_idx;

  // Last grantee; reset value makes requester 0 the top priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   last_q <= OWNER_W'(NREQ - 1);
    else if (upd) last_q <= upd_idx;
  end

  // First set request at or after last_q + 1, wrapping modulo NREQ.
  always_comb begin
    gnt      = '0;
    any      = 1'b0;
    pick_idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      pick_idx = (int'(last_q) + k) % NREQ;
      if (!any && req[pick_idx]) begin
        gnt[pick_idx] = 1'b1;
        any           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_load_arbiter.sv
// Shares one loadable up counter among NREQ requesters: round-robin grant,
// one-cycle load of the grantee's start value, then waits for count_in to
// hit TC and pulses done. Optional macro WATCHDOG_EN bounds the RUN phase
// to TIMEOUT cycles and reports expiry on err.
module counter_load_arbiter
  import counter_ctrl_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 4,
  parameter int TC      = 15,
  parameter int TIMEOUT = 20
) (
  input logic                    clk,
  input logic                    reset,
  counter_load_arbiter_if.master bus
);

  localparam logic [WIDTH-1:0] TC_V = WIDTH'(TC);

  state_t             state_q, state_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic               load_q, load_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [NREQ-1:0]    arb_gnt;
  logic               arb_any;
  logic [OWNER_W-1:0] arb_idx;
  logic               ptr_upd;
`ifdef WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (bus.req),
    .upd     (ptr_upd),
    .upd_idx (owner_q),
    .gnt     (arb_gnt),
    .any     (arb_any)
  );

  assign arb_idx = onehot_to_idx(8'(arb_gnt));

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    load_d  = 1'b0;
    data_d  = data_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ptr_upd = 1'b0;
`ifdef WATCHDOG_EN
    wd_d    = wd_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          gnt_d   = arb_gnt;
          load_d  = 1'b1;
          data_d  = bus.req_data[int'(arb_idx)*WIDTH +: WIDTH];
          owner_d = arb_idx;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Counter captures data_out on this edge; pointer moves to grantee.
        ptr_upd = 1'b1;
        state_d = RUN;
`ifdef WATCHDOG_EN
        wd_d    = '0;
`endif
      end
      RUN: begin
        if (bus.count_in == TC_V) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
`ifdef WATCHDOG_EN
        // TC match above has priority over an expiry on the same cycle.
        else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      load_q  <= 1'b0;
      data_q  <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef WATCHDOG_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      load_q  <= load_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef WATCHDOG_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.load      = load_q;
  assign bus.data_out  = data_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;
`ifdef WATCHDOG_EN
  assign bus.err       = err_q;
`endif

endmodule
